lfsr_engine: RTL and testbench

- Parametrised successor to the fixed 4-bit LFSR. Configurable width, Fibonacci or Galois feedback, reverse stepping, runtime seed load, single-step and N-step burst control, and period measurement.
- Sits behind the tt_um top wrapper: switch inputs drive the mode and control inputs, and the output bus drives uo_out.

---
 rtl/lfsr_pkg.sv | 26 ++
 rtl/lfsr_engine_next.sv | 39 +++
 rtl/lfsr_engine.sv | 191 +++++++++++++++++++
 tb/tb_lfsr_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Brief    : Shared mode encodings, FSM state type and helpers for lfsr_engine.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'b00;
    localparam logic [1:0] MODE_FIB_FWD = 2'b01;
    localparam logic [1:0] MODE_GAL_FWD = 2'b10;
    localparam logic [1:0] MODE_FIB_REV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // HOLD advances leave the register untouched and are not counted as steps.
    function automatic logic is_stepping_mode(input logic [1:0] mode);
        return (mode != MODE_HOLD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_engine_next.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_next
// Brief    : Combinational next-state function for Fibonacci/Galois LFSR modes.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] POLY  = 8'h1D
) (
    input  logic [WIDTH-1:0] lfsr,
    input  logic [1:0]       mod,
    output logic [WIDTH-1:0] next_lfsr
);

    logic             w_fib_fb;
    logic             w_rev_fb;
    logic [WIDTH-1:0] w_gal_mask;

    assign w_fib_fb   = ^(lfsr & TAPS);
    // Recovers the bit shifted out by the forward step; relies on TAPS[WIDTH-1]=1.
    assign w_rev_fb   = lfsr[0] ^ (^(lfsr[WIDTH-1:1] & TAPS[WIDTH-2:0]));
    assign w_gal_mask = lfsr[WIDTH-1] ? POLY : '0;

    always_comb begin
        next_lfsr = lfsr;
        case (mod)
            MODE_FIB_FWD: next_lfsr = {lfsr[WIDTH-2:0], w_fib_fb};
            MODE_GAL_FWD: next_lfsr = {lfsr[WIDTH-2:0], 1'b0} ^ w_gal_mask;
            MODE_FIB_REV: next_lfsr = {w_rev_fb, lfsr[WIDTH-1:1]};
            default:      next_lfsr = lfsr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_engine.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_engine
// Brief    : Configurable LFSR with run/step/burst control and period measure.
//            Optional zero-state recovery enabled by macro LFSR_LOCKUP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_engine
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] POLY  = 8'h1D,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mod,
    input  logic             en,
    input  logic             step,
    input  logic             start,
    input  logic [WIDTH-1:0] burst_len,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr,
    output logic             bit_out,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [WIDTH:0]   period,
    output logic             lockup
);

    localparam logic [WIDTH:0] c_cnt_max = '1;
    localparam logic [WIDTH:0] c_cnt_one = (WIDTH+1)'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_ref_seed;
    logic [WIDTH:0]   r_step_cnt;
    logic [WIDTH:0]   r_period;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] w_rem_next;
    logic             r_done;
    logic             r_wrap;
    logic             w_done_next;
    logic             w_adv;
    logic             w_step_taken;
    logic             w_burst_go;
    logic             w_burst_zero;
    logic             w_lockup_force;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH:0]   w_cnt_inc;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .POLY  (POLY)
    ) u_next (
        .lfsr      (r_lfsr),
        .mod       (mod),
        .next_lfsr (w_next)
    );

    assign w_burst_go   = start && (burst_len != '0);
    assign w_burst_zero = start && (burst_len == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // seed_load overrides every transition and aborts a burst without done.
    always_comb begin
        w_state_next = r_state;
        w_adv        = 1'b0;
        w_rem_next   = r_remaining;
        w_done_next  = 1'b0;
        if (seed_load) begin
            if (r_state == ST_BURST) begin
                w_state_next = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_adv = step;
                    if (w_burst_go) begin
                        w_state_next = ST_BURST;
                        w_rem_next   = burst_len;
                    end else begin
                        w_done_next = w_burst_zero;
                        if (en) begin
                            w_state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    w_adv = 1'b1;
                    if (w_burst_go) begin
                        w_state_next = ST_BURST;
                        w_rem_next   = burst_len;
                    end else begin
                        w_done_next = w_burst_zero;
                        if (!en) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                ST_BURST: begin
                    w_adv      = 1'b1;
                    w_rem_next = r_remaining - WIDTH'(1);
                    if (r_remaining <= WIDTH'(1)) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                        w_rem_next   = '0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

`ifdef LFSR_LOCKUP_EN
    logic r_lockup;

    assign w_lockup_force = (r_lfsr == '0) && !seed_load;

    always_ff @(posedge clk) begin
        if (reset || seed_load) begin
            r_lockup <= 1'b0;
        end else if (w_lockup_force) begin
            r_lockup <= 1'b1;
        end
    end

    assign lockup = r_lockup;
`else
    assign w_lockup_force = 1'b0;
    assign lockup         = 1'b0;
`endif

    assign w_step_taken = w_adv && is_stepping_mode(mod);
    assign w_cnt_inc    = (r_step_cnt == c_cnt_max) ? r_step_cnt : r_step_cnt + c_cnt_one;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr      <= SEED;
            r_ref_seed  <= SEED;
            r_step_cnt  <= '0;
            r_period    <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_done      <= w_done_next;
            r_wrap      <= 1'b0;
            r_remaining <= w_rem_next;
            if (seed_load) begin
                r_lfsr     <= seed_in;
                r_ref_seed <= seed_in;
                r_step_cnt <= '0;
            end else if (w_lockup_force) begin
                r_lfsr <= SEED;
            end else if (w_step_taken) begin
                r_lfsr <= w_next;
                if (w_next == r_ref_seed) begin
                    r_wrap     <= 1'b1;
                    r_period   <= w_cnt_inc;
                    r_step_cnt <= '0;
                end else begin
                    r_step_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign lfsr    = r_lfsr;
    assign bit_out = r_lfsr[WIDTH-1];
    assign busy    = (r_state == ST_BURST);
    assign done    = r_done;
    assign wrap    = r_wrap;
    assign period  = r_period;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_engine
// Brief    : Directed table-driven bench for lfsr_engine (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_engine;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mod;
    logic       en;
    logic       step;
    logic       start;
    logic [7:0] burst_len;
    logic       seed_load;
    logic [7:0] seed_in;
    logic [7:0] lfsr;
    logic       bit_out;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [8:0] period;
    logic       lockup;

    int checks   = 0;
    int failures = 0;

    lfsr_engine dut (
        .clk       (clk),
        .reset     (reset),
        .mod       (mod),
        .en        (en),
        .step      (step),
        .start     (start),
        .burst_len (burst_len),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .lfsr      (lfsr),
        .bit_out   (bit_out),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .period    (period),
        .lockup    (lockup)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mod;
        logic       en;
        logic       step;
        logic       start;
        logic [7:0] blen;
        logic       sload;
        logic [7:0] sin;
        logic [7:0] e_lfsr;
        logic       e_busy;
        logic       e_done;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[30];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_to_wrap(input string name, output int steps);
        logic [7:0] prev;
        bit         seen;
        steps = 0;
        seen  = 0;
        prev  = lfsr;
        for (int c = 0; c < 600 && !seen; c++) begin
            tick;
            if (lfsr !== prev) steps++;
            prev = lfsr;
            if (wrap === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout wrap=0 required=1", name);
        end
    endtask

    task automatic wait_done(input string name, output int cycles);
        bit seen;
        cycles = 0;
        seen   = 0;
        for (int c = 0; c < 600 && !seen; c++) begin
            tick;
            cycles++;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout done=0 required=1", name);
        end
    endtask

    task automatic idle_inputs;
        mod       = 2'b01;
        en        = 1'b0;
        step      = 1'b0;
        start     = 1'b0;
        burst_len = 8'h00;
        seed_load = 1'b0;
        seed_in   = 8'h00;
    endtask

    initial begin
        int n;
        logic [7:0] exp_zero_lfsr;
        logic       exp_zero_lock;

        // mod, en, step, start, blen, sload, sin, e_lfsr, e_busy, e_done, e_wrap
        vecs[0]  = '{2'b01, N, Y, N, 8'd0, N, 8'h00, 8'h02, N, N, N};
        vecs[1]  = '{2'b01, N, Y, N, 8'd0, N, 8'h00, 8'h04, N, N, N};
        vecs[2]  = '{2'b01, N, N, N, 8'd0, N, 8'h00, 8'h04, N, N, N};
        vecs[3]  = '{2'b01, N, Y, N, 8'd0, N, 8'h00, 8'h08, N, N, N};
        vecs[4]  = '{2'b01, N, Y, N, 8'd0, N, 8'h00, 8'h11, N, N, N};
        vecs[5]  = '{2'b11, N, N, N, 8'd0, Y, 8'h11, 8'h11, N, N, N};
        vecs[6]  = '{2'b11, N, Y, N, 8'd0, N, 8'h00, 8'h08, N, N, N};
        vecs[7]  = '{2'b11, N, Y, N, 8'd0, N, 8'h00, 8'h04, N, N, N};
        vecs[8]  = '{2'b00, N, Y, N, 8'd0, N, 8'h00, 8'h04, N, N, N};
        vecs[9]  = '{2'b10, N, Y, N, 8'd0, N, 8'h00, 8'h08, N, N, N};
        vecs[10] = '{2'b10, N, N, N, 8'd0, Y, 8'h80, 8'h80, N, N, N};
        vecs[11] = '{2'b10, N, Y, N, 8'd0, N, 8'h00, 8'h1D, N, N, N};
        vecs[12] = '{2'b10, N, Y, N, 8'd0, N, 8'h00, 8'h3A, N, N, N};
        vecs[13] = '{2'b01, N, N, N, 8'd0, Y, 8'h01, 8'h01, N, N, N};
        vecs[14] = '{2'b01, N, N, Y, 8'd5, N, 8'h00, 8'h01, Y, N, N};
        vecs[15] = '{2'b01, N, N, N, 8'd0, N, 8'h00, 8'h02, Y, N, N};
        vecs[16] = '{2'b01, Y, N, N, 8'd0, N, 8'h00, 8'h04, Y, N, N};
        vecs[17] = '{2'b01, N, Y, N, 8'd0, N, 8'h00, 8'h08, Y, N, N};
        vecs[18] = '{2'b01, N, N, Y, 8'd2, N, 8'h00, 8'h11, Y, N, N};
        vecs[19] = '{2'b01, N, N, N, 8'd0, N, 8'h00, 8'h23, N, Y, N};
        vecs[20] = '{2'b01, N, N, N, 8'd0, N, 8'h00, 8'h23, N, N, N};
        vecs[21] = '{2'b01, N, N, Y, 8'd0, N, 8'h00, 8'h23, N, Y, N};
        vecs[22] = '{2'b01, N, N, N, 8'd0, N, 8'h00, 8'h23, N, N, N};
        vecs[23] = '{2'b01, N, N, Y, 8'd3, N, 8'h00, 8'h23, Y, N, N};
        vecs[24] = '{2'b01, N, N, N, 8'd0, N, 8'h00, 8'h47, Y, N, N};
        vecs[25] = '{2'b01, N, N, N, 8'd0, Y, 8'h01, 8'h01, N, N, N};
        vecs[26] = '{2'b01, N, N, N, 8'd0, N, 8'h00, 8'h01, N, N, N};
        vecs[27] = '{2'b01, N, N, N, 8'd0, N, 8'h00, 8'h01, N, N, N};
        vecs[28] = '{2'b01, Y, N, Y, 8'd4, Y, 8'h5A, 8'h5A, N, N, N};
        vecs[29] = '{2'b01, N, N, N, 8'd0, N, 8'h00, 8'h5A, N, N, N};

        idle_inputs();
        reset = 1'b1;
        tick;
        tick;
        chk("reset_lfsr", lfsr, 8'h01);
        chk("reset_bit_out", bit_out, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_wrap", wrap, 1'b0);
        chk("reset_period", period, 9'h000);
        chk("reset_lockup", lockup, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            mod       = vecs[i].mod;
            en        = vecs[i].en;
            step      = vecs[i].step;
            start     = vecs[i].start;
            burst_len = vecs[i].blen;
            seed_load = vecs[i].sload;
            seed_in   = vecs[i].sin;
            tick;
            chk($sformatf("vec%0d_lfsr", i), lfsr, vecs[i].e_lfsr);
            chk($sformatf("vec%0d_bit_out", i), bit_out, vecs[i].e_lfsr[7]);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
            chk($sformatf("vec%0d_wrap", i), wrap, vecs[i].e_wrap);
        end
        idle_inputs();

        // Fibonacci full period from the reset seed.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        en    = 1'b1;
        run_to_wrap("fib_period", n);
        chk("fib_steps", n, 255);
        chk("fib_wrap_lfsr", lfsr, 8'h01);
        chk("fib_period_val", period, 9'd255);
        en = 1'b0;
        tick;
        chk("fib_wrap_pulse_end", wrap, 1'b0);

        // Galois: 7 single steps reach 0x80, the 8th folds in POLY.
        seed_load = 1'b1;
        seed_in   = 8'h01;
        tick;
        seed_load = 1'b0;
        mod       = 2'b10;
        step      = 1'b1;
        repeat (7) tick;
        step = 1'b0;
        chk("gal_step7", lfsr, 8'h80);
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("gal_step8", lfsr, 8'h1D);
        en = 1'b1;
        run_to_wrap("gal_period", n);
        chk("gal_steps", n + 8, 255);
        chk("gal_period_val", period, 9'd255);
        chk("gal_wrap_lfsr", lfsr, 8'h01);
        en = 1'b0;
        tick;

        // 255 forward then 255 reverse steps via bursts return to 0x11.
        seed_load = 1'b1;
        seed_in   = 8'h11;
        mod       = 2'b01;
        tick;
        seed_load = 1'b0;
        start     = 1'b1;
        burst_len = 8'd255;
        tick;
        start = 1'b0;
        chk("fwd_burst_busy", busy, 1'b1);
        wait_done("fwd_burst", n);
        chk("fwd_burst_cycles", n, 255);
        chk("fwd_burst_lfsr", lfsr, 8'h11);
        chk("fwd_burst_period", period, 9'd255);
        chk("fwd_burst_idle", busy, 1'b0);
        mod   = 2'b11;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done("rev_burst", n);
        chk("rev_burst_cycles", n, 255);
        chk("rev_burst_lfsr", lfsr, 8'h11);
        chk("rev_burst_period", period, 9'd255);
        tick;
        chk("rev_done_pulse_end", done, 1'b0);

        // Reset in the middle of a free run.
        mod = 2'b01;
        en  = 1'b1;
        repeat (3) tick;
        reset = 1'b1;
        tick;
        chk("mid_reset_lfsr", lfsr, 8'h01);
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_done", done, 1'b0);
        chk("mid_reset_wrap", wrap, 1'b0);
        chk("mid_reset_period", period, 9'h000);
        chk("mid_reset_lockup", lockup, 1'b0);
        reset = 1'b0;
        en    = 1'b0;
        tick;
        chk("post_reset_idle", lfsr, 8'h01);

        // All-zero seed.
`ifdef LFSR_LOCKUP_EN
        exp_zero_lfsr = 8'h01;
        exp_zero_lock = 1'b1;
`else
        exp_zero_lfsr = 8'h00;
        exp_zero_lock = 1'b0;
`endif
        seed_load = 1'b1;
        seed_in   = 8'h00;
        tick;
        seed_load = 1'b0;
        chk("zero_load_lfsr", lfsr, 8'h00);
        chk("zero_load_lockup", lockup, 1'b0);
        tick;
        chk("zero_next_lfsr", lfsr, exp_zero_lfsr);
        chk("zero_next_lockup", lockup, exp_zero_lock);
        tick;
        chk("zero_hold_lfsr", lfsr, exp_zero_lfsr);
        chk("zero_hold_lockup", lockup, exp_zero_lock);
        seed_load = 1'b1;
        seed_in   = 8'h42;
        tick;
        seed_load = 1'b0;
        chk("reload_lfsr", lfsr, 8'h42);
        chk("reload_lockup", lockup, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
